// File: rtl/vline_fetch.sv
// Line-fetch engine: turns output-stage line requests into burst reads
// and streams the returned pixels into the line buffer.
module vline_fetch #(
  parameter int ADDR_W     = 22,
  parameter int LINE_SHIFT = 10,
  parameter int BASE_ADDR  = 0,
  parameter int BURST_LEN  = 16,
  parameter int MAX_PIXELS = 512
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_enable,
  input  logic [8:0]        i_line_idx,
  input  logic              i_line_end,
  input  logic              i_frame_end,
  input  logic [11:0]       i_x_win_size,
  output logic              o_rd_req,
  output logic [ADDR_W-1:0] o_rd_addr,
  output logic [7:0]        o_rd_len,
  input  logic              i_rd_ack,
  input  logic              i_rd_valid,
  input  logic [11:0]       i_rd_data,
  output logic              o_vdata_valid,
  output logic              o_vdata_reset,
  output logic [11:0]       o_vdata,
  output logic              o_busy,
  output logic              o_late
);

  typedef enum logic [1:0] {IDLE, LRST, REQ, DATA} state_t;

  localparam logic [11:0] MAXP = 12'(MAX_PIXELS);
  localparam logic [9:0]  BL   = 10'(BURST_LEN);

  state_t            state_q, state_d;
  logic              le_q, fe_q;
  logic              pend_v_q, pend_v_d;
  logic [8:0]        pend_idx_q, pend_idx_d;
  logic [9:0]        pend_cnt_q, pend_cnt_d;
  logic              late_q, late_d;
  logic [8:0]        idx_q, idx_d;
  logic [9:0]        rem_q, rem_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        blen_q, blen_d;
  logic [7:0]        beat_q, beat_d;
  logic [11:0]       vdata_q, vdata_d;
  logic              vvalid_q, vvalid_d;

  logic              line_edge, frame_edge;
  logic [9:0]        clamp_cnt;
  logic [7:0]        rd_len;
  logic [ADDR_W-1:0] line_base;

  assign line_edge  = i_line_end & ~le_q;
  assign frame_edge = i_frame_end & ~fe_q;
  assign clamp_cnt  = (i_x_win_size > MAXP) ? MAXP[9:0]
                                            : i_x_win_size[9:0];
  assign rd_len     = (rem_q > BL) ? BL[7:0] : rem_q[7:0];
  assign line_base  = ADDR_W'(BASE_ADDR)
                    + (ADDR_W'(idx_q) << LINE_SHIFT);

  always_comb begin
    state_d    = state_q;
    pend_v_d   = pend_v_q;
    pend_idx_d = pend_idx_q;
    pend_cnt_d = pend_cnt_q;
    late_d     = late_q;
    idx_d      = idx_q;
    rem_d      = rem_q;
    addr_d     = addr_q;
    blen_d     = blen_q;
    beat_d     = beat_q;
    vdata_d    = vdata_q;
    vvalid_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (pend_v_q) begin
          idx_d    = pend_idx_q;
          rem_d    = pend_cnt_q;
          pend_v_d = 1'b0;
          state_d  = LRST;
        end
      end
      LRST: begin
        addr_d  = line_base;
        state_d = (rem_q == 10'd0) ? IDLE : REQ;
      end
      REQ: begin
        if (i_rd_ack) begin
          blen_d  = rd_len;
          beat_d  = rd_len;
          state_d = DATA;
        end
      end
      DATA: begin
        if (i_rd_valid) begin
          vdata_d  = i_rd_data;
          vvalid_d = 1'b1;
          beat_d   = beat_q - 8'd1;
          rem_d    = rem_q - 10'd1;
          if (beat_q == 8'd1) begin
            addr_d  = addr_q + ADDR_W'(blen_q);
            state_d = (rem_q == 10'd1) ? IDLE : REQ;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // frame clear wins, then a same-cycle line request refills the slot
    if (frame_edge) begin
      pend_v_d = 1'b0;
      late_d   = 1'b0;
    end
    if (line_edge && i_enable) begin
      if (pend_v_d) late_d = 1'b1;
      pend_v_d   = 1'b1;
      pend_idx_d = i_line_idx;
      pend_cnt_d = clamp_cnt;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= IDLE;
      le_q       <= 1'b0;
      fe_q       <= 1'b0;
      pend_v_q   <= 1'b0;
      pend_idx_q <= '0;
      pend_cnt_q <= '0;
      late_q     <= 1'b0;
      idx_q      <= '0;
      rem_q      <= '0;
      addr_q     <= '0;
      blen_q     <= '0;
      beat_q     <= '0;
      vdata_q    <= '0;
      vvalid_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      le_q       <= i_line_end;
      fe_q       <= i_frame_end;
      pend_v_q   <= pend_v_d;
      pend_idx_q <= pend_idx_d;
      pend_cnt_q <= pend_cnt_d;
      late_q     <= late_d;
      idx_q      <= idx_d;
      rem_q      <= rem_d;
      addr_q     <= addr_d;
      blen_q     <= blen_d;
      beat_q     <= beat_d;
      vdata_q    <= vdata_d;
      vvalid_q   <= vvalid_d;
    end
  end

  assign o_rd_req      = (state_q == REQ);
  assign o_rd_addr     = o_rd_req ? addr_q : '0;
  assign o_rd_len      = o_rd_req ? rd_len : 8'd0;
  assign o_vdata_reset = (state_q == LRST);
  assign o_vdata_valid = vvalid_q;
  assign o_vdata       = vdata_q;
  assign o_busy        = (state_q != IDLE) | pend_v_q;
  assign o_late        = late_q;

endmodule

// File: tb/tb_vline_fetch.sv
// Directed-plus-random bench for vline_fetch with a behavioural
// memory and line model; a 12-bit-address twin checks address wrap.
module tb_vline_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_enable, i_line_end, i_frame_end;
  logic [8:0]  i_line_idx;
  logic [11:0] i_x_win_size;
  logic        i_rd_ack, i_rd_valid;
  logic [11:0] i_rd_data;

  logic        o_rd_req, o_vdata_valid, o_vdata_reset, o_busy, o_late;
  logic [21:0] o_rd_addr;
  logic [7:0]  o_rd_len;
  logic [11:0] o_vdata;

  logic        b_rd_req, b_vdata_valid, b_vdata_reset, b_busy, b_late;
  logic [11:0] b_rd_addr;
  logic [7:0]  b_rd_len;
  logic [11:0] b_vdata;

  int total = 0;
  int bad   = 0;
  int rst_cnt = 0;
  logic [11:0] got_q[$];
  logic [11:0] exp_q[$];

  always #5 clk = ~clk;

  vline_fetch dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_enable(i_enable),
    .i_line_idx(i_line_idx), .i_line_end(i_line_end),
    .i_frame_end(i_frame_end), .i_x_win_size(i_x_win_size),
    .o_rd_req(o_rd_req), .o_rd_addr(o_rd_addr), .o_rd_len(o_rd_len),
    .i_rd_ack(i_rd_ack), .i_rd_valid(i_rd_valid),
    .i_rd_data(i_rd_data), .o_vdata_valid(o_vdata_valid),
    .o_vdata_reset(o_vdata_reset), .o_vdata(o_vdata),
    .o_busy(o_busy), .o_late(o_late)
  );

  vline_fetch #(.ADDR_W(12)) dut_w (
    .i_clk(clk), .i_reset_n(rst_n), .i_enable(i_enable),
    .i_line_idx(i_line_idx), .i_line_end(i_line_end),
    .i_frame_end(i_frame_end), .i_x_win_size(i_x_win_size),
    .o_rd_req(b_rd_req), .o_rd_addr(b_rd_addr), .o_rd_len(b_rd_len),
    .i_rd_ack(i_rd_ack), .i_rd_valid(i_rd_valid),
    .i_rd_data(i_rd_data), .o_vdata_valid(b_vdata_valid),
    .o_vdata_reset(b_vdata_reset), .o_vdata(b_vdata),
    .o_busy(b_busy), .o_late(b_late)
  );

  always @(negedge clk) begin
    if (o_vdata_valid) got_q.push_back(o_vdata);
    if (o_vdata_reset) rst_cnt++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [11:0] mem(input logic [21:0] a);
    logic [21:0] t;
    t = (a * 22'd13 + 22'd7) ^ (a >> 3);
    return t[11:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic line_edge(input int idx, input int xw);
    i_line_idx   = 9'(idx);
    i_x_win_size = 12'(xw);
    i_line_end   = 1'b1;
    @(negedge clk);
    i_line_end   = 1'b0;
    @(negedge clk);
  endtask

  task automatic frame_pulse();
    i_frame_end = 1'b1;
    @(negedge clk);
    i_frame_end = 1'b0;
    @(negedge clk);
  endtask

  task automatic serve_burst(input logic [21:0] ea, input int el,
                             input int dly);
    int w = 0;
    while (!o_rd_req && w < 40) begin
      @(negedge clk);
      w++;
    end
    chk("rd_req", 32'(o_rd_req), 1);
    if (!o_rd_req) return;
    chk("rd_addr", 32'(o_rd_addr), 32'(ea));
    chk("rd_len", 32'(o_rd_len), el);
    chk("rd_addr_w12", 32'(b_rd_addr), 32'(ea[11:0]));
    repeat (dly) begin
      @(negedge clk);
      chk("stall_req", 32'(o_rd_req), 1);
      chk("stall_addr", 32'(o_rd_addr), 32'(ea));
    end
    i_rd_ack = 1'b1;
    @(negedge clk);
    i_rd_ack = 1'b0;
    for (int b = 0; b < el; b++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      i_rd_valid = 1'b1;
      i_rd_data  = mem(ea + 22'(b));
      @(negedge clk);
      i_rd_valid = 1'b0;
    end
  endtask

  task automatic fetch_line(input int idx, input int xw, input int dly0);
    int cnt;
    logic [21:0] base;
    cnt  = (xw > 512) ? 512 : xw;
    base = 22'(idx << 10);
    for (int off = 0; off < cnt; off += 16) begin
      int len;
      len = (cnt - off < 16) ? cnt - off : 16;
      serve_burst(base + 22'(off), len,
                  (off == 0) ? dly0 : int'($urandom_range(0, 2)));
    end
    for (int k = 0; k < cnt; k++) exp_q.push_back(mem(base + 22'(k)));
  endtask

  task automatic cmp_pix(input string tag);
    int n;
    repeat (3) @(negedge clk);
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk(tag, 32'(got_q[i]), 32'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    rst_n = 1'b0;
    i_enable = 1'b1;
    i_line_end = 1'b0;
    i_frame_end = 1'b0;
    i_line_idx = '0;
    i_x_win_size = '0;
    i_rd_ack = 1'b0;
    i_rd_valid = 1'b0;
    i_rd_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_req", 32'(o_rd_req), 0);
    chk("rst_addr", 32'(o_rd_addr), 0);
    chk("rst_len", 32'(o_rd_len), 0);
    chk("rst_vvalid", 32'(o_vdata_valid), 0);
    chk("rst_vreset", 32'(o_vdata_reset), 0);
    chk("rst_vdata", 32'(o_vdata), 0);
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_late", 32'(o_late), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // basic line with latency and stray-beat checks
    rst_cnt = 0;
    line_edge(3, 40);
    chk("lat_vreset", 32'(o_vdata_reset), 1);
    chk("lat_busy", 32'(o_busy), 1);
    @(negedge clk);
    chk("lat_vreset_off", 32'(o_vdata_reset), 0);
    chk("lat_req", 32'(o_rd_req), 1);
    fetch_line(3, 40, 0);
    i_rd_valid = 1'b1;
    i_rd_data  = 12'd123;
    @(negedge clk);
    i_rd_valid = 1'b0;
    cmp_pix("basic");
    chk("basic_vreset_cnt", rst_cnt, 1);
    chk("basic_idle", 32'(o_busy), 0);

    // zero width
    rst_cnt = 0;
    line_edge(7, 0);
    chk("zero_vreset", 32'(o_vdata_reset), 1);
    @(negedge clk);
    chk("zero_busy", 32'(o_busy), 0);
    chk("zero_req", 32'(o_rd_req), 0);
    repeat (5) @(negedge clk);
    chk("zero_req_late", 32'(o_rd_req), 0);
    chk("zero_vreset_cnt", rst_cnt, 1);

    // clamp, ack stall, enable falling mid-fetch
    line_edge(1, 4095);
    i_enable = 1'b0;
    fetch_line(1, 4095, 5);
    cmp_pix("clamp");
    line_edge(2, 10);
    repeat (10) @(negedge clk);
    chk("dis_busy", 32'(o_busy), 0);
    chk("dis_req", 32'(o_rd_req), 0);
    i_enable = 1'b1;

    // back-to-back, overrun
    line_edge(5, 20);
    line_edge(6, 20);
    chk("b2b_late0", 32'(o_late), 0);
    line_edge(7, 24);
    chk("b2b_late1", 32'(o_late), 1);
    fetch_line(5, 20, 1);
    fetch_line(7, 24, 0);
    cmp_pix("b2b");
    repeat (10) @(negedge clk);
    chk("b2b_busy", 32'(o_busy), 0);
    chk("late_sticky", 32'(o_late), 1);
    frame_pulse();
    chk("frame_late_clr", 32'(o_late), 0);

    // frame edge empties a full slot
    line_edge(9, 8);
    line_edge(10, 8);
    line_edge(11, 8);
    chk("frame_late_set", 32'(o_late), 1);
    frame_pulse();
    chk("frame_late_clr2", 32'(o_late), 0);
    fetch_line(9, 8, 0);
    cmp_pix("frame");
    repeat (20) @(negedge clk);
    chk("frame_slot_empty", 32'(o_busy), 0);

    // frame and line edge together: clear then latch
    line_edge(13, 4);
    line_edge(14, 4);
    i_frame_end = 1'b1;
    line_edge(12, 4);
    i_frame_end = 1'b0;
    chk("same_late", 32'(o_late), 0);
    fetch_line(13, 4, 0);
    fetch_line(12, 4, 0);
    cmp_pix("same");
    repeat (10) @(negedge clk);
    chk("same_busy", 32'(o_busy), 0);

    // async reset mid-DATA
    line_edge(2, 40);
    for (int w = 0; w < 10 && !o_rd_req; w++) @(negedge clk);
    chk("ar_req", 32'(o_rd_req), 1);
    i_rd_ack = 1'b1;
    @(negedge clk);
    i_rd_ack = 1'b0;
    for (int b = 0; b < 5; b++) begin
      i_rd_valid = 1'b1;
      i_rd_data  = mem(22'(2048 + b));
      @(negedge clk);
    end
    chk("ar_vvalid_pre", 32'(o_vdata_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_req0", 32'(o_rd_req), 0);
    chk("ar_vvalid0", 32'(o_vdata_valid), 0);
    chk("ar_vreset0", 32'(o_vdata_reset), 0);
    chk("ar_vdata0", 32'(o_vdata), 0);
    chk("ar_busy0", 32'(o_busy), 0);
    chk("ar_late0", 32'(o_late), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    got_q.delete();
    exp_q.delete();
    repeat (4) @(negedge clk);
    i_rd_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("ar_stray", got_q.size(), 0);
    chk("ar_req_after", 32'(o_rd_req), 0);
    chk("ar_busy_after", 32'(o_busy), 0);

    // address wrap on the 12-bit twin
    line_edge(3, 32);
    fetch_line(3, 32, 0);
    line_edge(4, 16);
    fetch_line(4, 16, 0);
    cmp_pix("wrap");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
